// File: rtl/line_fill_buffer.sv
`default_nettype none
// ============================================================================
// Module   : line_fill_buffer
// Purpose  : single-entry cache-line buffer with fill and dirty writeback
// Revision : 1.0
// ============================================================================
module line_fill_buffer #(
  parameter int WORD_W    = 16,
  parameter int NUM_WORDS = 8,
  parameter int TAG_W     = 12
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [15:0]                 mem_address,
  input  logic                        mem_read,
  input  logic                        mem_write,
  input  logic [WORD_W/8-1:0]         mem_wmask,
  input  logic [WORD_W-1:0]           mem_wdata,
  output logic                        mem_resp,
  output logic [WORD_W*NUM_WORDS-1:0] line_data,
  output logic [$clog2(NUM_WORDS)-1:0] word_sel,
  output logic [15:0]                 pmem_address,
  output logic                        pmem_read,
  output logic                        pmem_write,
  output logic [WORD_W*NUM_WORDS-1:0] pmem_wdata,
  input  logic [WORD_W*NUM_WORDS-1:0] pmem_rdata,
  input  logic                        pmem_resp
);

  localparam int LINE_W = WORD_W * NUM_WORDS;
  localparam int OFF_W  = 16 - TAG_W;
  localparam int SEL_W  = $clog2(NUM_WORDS);
  localparam int BYTES  = WORD_W / 8;

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_WRITEBACK = 2'd1;
  localparam logic [1:0] S_FILL      = 2'd2;

  logic [1:0]        state_q, state_d;
  logic              valid_q, valid_d;
  logic              dirty_q, dirty_d;
  logic [TAG_W-1:0]  tag_q,   tag_d;
  logic [LINE_W-1:0] line_q,  line_d;

  logic              w_req;
  logic              w_hit;
  logic [TAG_W-1:0]  w_addr_tag;
  logic              w_unused_lsb;

  assign w_addr_tag   = mem_address[15:OFF_W];
  assign w_req        = mem_read | mem_write;
  assign w_hit        = valid_q && (tag_q == w_addr_tag);
  assign w_unused_lsb = mem_address[0];

  assign word_sel   = mem_address[SEL_W:1];
  assign line_data  = line_q;
  assign pmem_wdata = line_q;

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (w_req && !w_hit) begin
          state_d = (valid_q && dirty_q) ? S_WRITEBACK : S_FILL;
        end
      end
      S_WRITEBACK: begin
        if (pmem_resp) begin
          state_d = S_FILL;
        end
      end
      S_FILL: begin
        if (pmem_resp) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs; the writeback address comes from the held tag, the fill
  // address tracks the CPU request
  always_comb begin
    mem_resp     = 1'b0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = {w_addr_tag, {OFF_W{1'b0}}};
    case (state_q)
      S_IDLE: begin
        mem_resp = w_req && w_hit;
      end
      S_WRITEBACK: begin
        pmem_write   = 1'b1;
        pmem_address = {tag_q, {OFF_W{1'b0}}};
      end
      S_FILL: begin
        pmem_read = 1'b1;
      end
      default: ;
    endcase
  end

  // Line, tag and status updates
  always_comb begin
    valid_d = valid_q;
    dirty_d = dirty_q;
    tag_d   = tag_q;
    line_d  = line_q;
    case (state_q)
      S_IDLE: begin
        if (mem_write && w_hit) begin
          for (int b = 0; b < BYTES; b++) begin
            if (mem_wmask[b]) begin
              line_d[int'(word_sel) * WORD_W + b * 8 +: 8] = mem_wdata[b * 8 +: 8];
            end
          end
          if (|mem_wmask) begin
            dirty_d = 1'b1;
          end
        end
      end
      S_WRITEBACK: begin
        if (pmem_resp) begin
          dirty_d = 1'b0;
        end
      end
      S_FILL: begin
        if (pmem_resp) begin
          line_d  = pmem_rdata;
          tag_d   = w_addr_tag;
          valid_d = 1'b1;
          dirty_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      dirty_q <= 1'b0;
      tag_q   <= '0;
      line_q  <= '0;
    end else begin
      valid_q <= valid_d;
      dirty_q <= dirty_d;
      tag_q   <= tag_d;
      line_q  <= line_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_line_fill_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_line_fill_buffer
// Purpose  : randomized self-checking bench for line_fill_buffer
// Revision : 1.0
// ============================================================================
module tb_line_fill_buffer;

  logic         clk = 1'b0;
  logic         reset;
  logic [15:0]  mem_address;
  logic         mem_read;
  logic         mem_write;
  logic [1:0]   mem_wmask;
  logic [15:0]  mem_wdata;
  logic         mem_resp;
  logic [127:0] line_data;
  logic [2:0]   word_sel;
  logic [15:0]  pmem_address;
  logic         pmem_read;
  logic         pmem_write;
  logic [127:0] pmem_wdata;
  logic [127:0] pmem_rdata;
  logic         pmem_resp;

  int checks = 0;
  int errors = 0;

  // Reference model: buffer contents as a word array plus a sparse memory
  logic         m_valid;
  logic         m_dirty;
  logic [11:0]  m_tag;
  logic [15:0]  m_words [8];
  logic [127:0] mem [logic [11:0]];

  always #5 clk = ~clk;

  line_fill_buffer dut (
    .clk          (clk),
    .reset        (reset),
    .mem_address  (mem_address),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_wmask    (mem_wmask),
    .mem_wdata    (mem_wdata),
    .mem_resp     (mem_resp),
    .line_data    (line_data),
    .word_sel     (word_sel),
    .pmem_address (pmem_address),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_wdata   (pmem_wdata),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] pack_line();
    logic [127:0] r;
    for (int k = 0; k < 8; k++) r[k*16 +: 16] = m_words[k];
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_valid = 1'b0;
    m_dirty = 1'b0;
    m_tag   = '0;
    for (int k = 0; k < 8; k++) m_words[k] = '0;
  endtask

  task automatic mem_line(input logic [11:0] t, output logic [127:0] l);
    if (!mem.exists(t)) mem[t] = {$urandom(), $urandom(), $urandom(), $urandom()};
    l = mem[t];
  endtask

  // One CPU request, serviced to completion with the given memory delays
  task automatic access(input logic [15:0] a, input logic rd, input logic wr,
                        input logic [15:0] wd, input logic [1:0] wm,
                        input int dwb, input int dfl, input bit drop);
    logic [127:0] fl;
    logic [15:0]  w;
    logic [2:0]   idx;
    idx = a[3:1];
    mem_address = a; mem_read = rd; mem_write = wr; mem_wdata = wd; mem_wmask = wm;
    #1;
    chk("word_sel", {125'd0, word_sel}, {125'd0, idx});
    if (!(m_valid && m_tag == a[15:4])) begin
      chk("miss_resp", {127'd0, mem_resp}, 128'd0);
      chk("idle_pread", {127'd0, pmem_read}, 128'd0);
      chk("idle_pwrite", {127'd0, pmem_write}, 128'd0);
      step();
      if (drop) begin
        mem_read = 1'b0;
        mem_write = 1'b0;
      end
      if (m_valid && m_dirty) begin
        for (int i = 0; i <= dwb; i++) begin
          #1;
          chk("wb_pwrite", {127'd0, pmem_write}, 128'd1);
          chk("wb_pread", {127'd0, pmem_read}, 128'd0);
          chk("wb_addr", {112'd0, pmem_address}, {112'd0, m_tag, 4'h0});
          chk("wb_data", pmem_wdata, pack_line());
          chk("wb_resp", {127'd0, mem_resp}, 128'd0);
          if (i == dwb) pmem_resp = 1'b1;
          step();
          pmem_resp = 1'b0;
        end
        mem[m_tag] = pack_line();
        m_dirty = 1'b0;
      end
      mem_line(a[15:4], fl);
      for (int i = 0; i <= dfl; i++) begin
        #1;
        chk("fill_pread", {127'd0, pmem_read}, 128'd1);
        chk("fill_pwrite", {127'd0, pmem_write}, 128'd0);
        chk("fill_addr", {112'd0, pmem_address}, {112'd0, a[15:4], 4'h0});
        chk("fill_resp", {127'd0, mem_resp}, 128'd0);
        if (i == dfl) begin
          pmem_rdata = fl;
          pmem_resp = 1'b1;
        end
        step();
        pmem_resp = 1'b0;
        pmem_rdata = {$urandom(), $urandom(), $urandom(), $urandom()};
      end
      m_valid = 1'b1;
      m_dirty = 1'b0;
      m_tag   = a[15:4];
      for (int k = 0; k < 8; k++) m_words[k] = fl[k*16 +: 16];
      if (drop) begin
        #1;
        chk("drop_resp", {127'd0, mem_resp}, 128'd0);
        chk("drop_pread", {127'd0, pmem_read}, 128'd0);
        chk("drop_line", line_data, pack_line());
        return;
      end
      #1;
    end
    chk("hit_resp", {127'd0, mem_resp}, 128'd1);
    chk("hit_pread", {127'd0, pmem_read}, 128'd0);
    chk("hit_pwrite", {127'd0, pmem_write}, 128'd0);
    chk("hit_word", {112'd0, line_data[int'(idx)*16 +: 16]}, {112'd0, m_words[idx]});
    if (wr) begin
      w = m_words[idx];
      if (wm[1]) w[15:8] = wd[15:8];
      if (wm[0]) w[7:0]  = wd[7:0];
      m_words[idx] = w;
      if (wm != 2'b00) m_dirty = 1'b1;
    end
    step();
    mem_read = 1'b0;
    mem_write = 1'b0;
    #1;
    chk("post_line", line_data, pack_line());
    chk("post_resp", {127'd0, mem_resp}, 128'd0);
  endtask

  task automatic stray_resp();
    pmem_rdata = {$urandom(), $urandom(), $urandom(), $urandom()};
    pmem_resp = 1'b1;
    step();
    pmem_resp = 1'b0;
    #1;
    chk("stray_line", line_data, pack_line());
    chk("stray_pread", {127'd0, pmem_read}, 128'd0);
  endtask

  initial begin
    logic [11:0]  tags [5];
    logic [127:0] l;
    tags = '{12'h123, 12'h200, 12'h345, 12'h567, 12'h700};

    for (int k = 0; k < 8; k++) l[k*16 +: 16] = 16'h1000 + 16'(k);
    mem[12'h123] = l;
    model_reset();
    reset = 1'b1;
    mem_address = 16'h1236; mem_read = 1'b1; mem_write = 1'b0;
    mem_wmask = 2'b00; mem_wdata = 16'h0000;
    pmem_rdata = '0; pmem_resp = 1'b0;
    step();
    step();
    reset = 1'b0;
    #1;
    chk("rst_resp", {127'd0, mem_resp}, 128'd0);
    chk("rst_pread", {127'd0, pmem_read}, 128'd0);
    chk("rst_pwrite", {127'd0, pmem_write}, 128'd0);
    chk("rst_line", line_data, 128'd0);

    // Clean miss then hit on 0x1236
    access(16'h1236, 1'b1, 1'b0, 16'h0, 2'b00, 0, 2, 1'b0);
    chk("t1_word3", {112'd0, line_data[63:48]}, {112'd0, 16'h1003});

    // High-byte write hit
    access(16'h1234, 1'b0, 1'b1, 16'hABCD, 2'b10, 0, 0, 1'b0);
    chk("t2_word2", {112'd0, line_data[47:32]}, {112'd0, 16'hAB02});

    // Dirty miss: writeback then fill
    access(16'h2000, 1'b1, 1'b0, 16'h0, 2'b00, 1, 1, 1'b0);

    // Long fill wait
    access(16'h3450, 1'b1, 1'b0, 16'h0, 2'b00, 0, 6, 1'b0);

    // Reset during fill
    mem_address = 16'h5670; mem_read = 1'b1; mem_write = 1'b0;
    #1;
    chk("r5_miss", {127'd0, mem_resp}, 128'd0);
    step();
    #1;
    chk("r5_fill", {127'd0, pmem_read}, 128'd1);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    chk("r5_pread", {127'd0, pmem_read}, 128'd0);
    chk("r5_pwrite", {127'd0, pmem_write}, 128'd0);
    chk("r5_resp", {127'd0, mem_resp}, 128'd0);
    chk("r5_line", line_data, 128'd0);
    model_reset();
    access(16'h5670, 1'b1, 1'b0, 16'h0, 2'b00, 0, 1, 1'b0);

    // Empty-mask write must not dirty the line: the next miss goes straight to fill
    access(16'h5672, 1'b0, 1'b1, 16'hFFFF, 2'b00, 0, 0, 1'b0);
    access(16'h7000, 1'b1, 1'b0, 16'h0, 2'b00, 0, 1, 1'b0);

    // Read and write together behave as a write
    access(16'h700E, 1'b1, 1'b1, 16'h5A5A, 2'b11, 0, 0, 1'b0);

    for (int n = 0; n < 200; n++) begin
      logic [15:0] a;
      logic        rd, wr;
      a  = {tags[$urandom_range(0, 4)], 4'($urandom_range(0, 15))};
      wr = 1'($urandom_range(0, 1));
      rd = wr ? 1'($urandom_range(0, 1)) : 1'b1;
      access(a, rd, wr, 16'($urandom()), 2'($urandom_range(0, 3)),
             $urandom_range(0, 4), $urandom_range(0, 4), ($urandom_range(0, 9) == 0));
      if ($urandom_range(0, 7) == 0) stray_resp();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
